// File: rtl/mest_pro_imem.sv
// MEST Pro instruction memory responder.
// Serves single-word fetches after a fixed read latency. Holds the returned word
// until the next read completes. A load port fills the array before the core
// starts running.
module mest_pro_imem #(
    parameter int OP_CODE_SIZE     = 4,
    parameter int INSTRUCTION_SIZE = OP_CODE_SIZE + 24,
    parameter int ROM_DEPTH        = 256,
    parameter int READ_LATENCY     = 2   // legal range 1..4
) (
    input  logic                          clk,
    input  logic                          i_reset,
    input  logic                          i_req,
    input  logic [$clog2(ROM_DEPTH)-1:0]  i_prog_counter,
    output logic [INSTRUCTION_SIZE-1:0]   o_instruction,
    output logic                          o_valid,
    output logic                          o_busy,
    output logic                          o_addr_err,
    input  logic                          i_load_en,
    input  logic                          i_load_valid,
    input  logic [$clog2(ROM_DEPTH)-1:0]  i_load_addr,
    input  logic [INSTRUCTION_SIZE-1:0]   i_load_data,
    output logic                          o_load_ready,
    output logic [$clog2(ROM_DEPTH):0]    o_load_count
);

    localparam int ADDR_W = $clog2(ROM_DEPTH);
    // Two bits cover READ_LATENCY-1 for every legal latency (0..3).
    localparam int CNT_W  = 2;

    // Depth widened by one bit so the range check never overflows, even for a
    // power-of-two depth where ROM_DEPTH itself needs ADDR_W+1 bits.
    localparam logic [ADDR_W:0] DEPTH_W = ROM_DEPTH[ADDR_W:0];

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_LOAD = 2'd2
    } state_t;

    state_t                      state;
    logic [CNT_W-1:0]            lat_cnt;
    logic [ADDR_W-1:0]           addr_p0;
    logic                        load_we;
    logic [INSTRUCTION_SIZE-1:0] mem [ROM_DEPTH];

    // True when the address maps onto a physical word. Addresses beyond the end
    // only exist for a non-power-of-two depth.
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_W);
    endfunction

    // Load-counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] c);
        return (&c) ? c : c + {{ADDR_W{1'b0}}, 1'b1};
    endfunction

    // A write happens only while load mode is held; the exit cycle and a reset
    // cycle both suppress the strobe.
    assign load_we = (state == S_LOAD) && i_load_en && i_load_valid && !i_reset;

    // Memory array: written from the load port only, never cleared by reset.
    always_ff @(posedge clk) begin
        if (load_we && in_range(i_load_addr)) begin
            mem[i_load_addr] <= i_load_data;
        end
    end

    // Fetch address capture on request acceptance; pure data, so no reset.
    always_ff @(posedge clk) begin
        if ((state == S_IDLE) && !i_load_en && i_req) begin
            addr_p0 <= i_prog_counter;
        end
    end

    // Control FSM with registered outputs: IDLE / READ / LOAD.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            state         <= S_IDLE;
            lat_cnt       <= '0;
            o_instruction <= '0;
            o_valid       <= 1'b0;
            o_addr_err    <= 1'b0;
            o_busy        <= 1'b0;
            o_load_ready  <= 1'b0;
            o_load_count  <= '0;
        end else begin
            // Completion flags are single-cycle pulses by default.
            o_valid    <= 1'b0;
            o_addr_err <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    // Load mode wins over a same-cycle fetch; that fetch is dropped.
                    if (i_load_en) begin
                        state        <= S_LOAD;
                        o_busy       <= 1'b1;
                        o_load_ready <= 1'b1;
                        o_load_count <= '0;
                    end else if (i_req) begin
                        state   <= S_READ;
                        o_busy  <= 1'b1;
                        lat_cnt <= CNT_W'(READ_LATENCY - 1);
                    end
                end
                S_READ: begin
                    if (lat_cnt == '0) begin
                        // Out-of-range fetches return the all-zero (opcode 0) word.
                        o_instruction <= in_range(addr_p0) ? mem[addr_p0] : '0;
                        o_addr_err    <= !in_range(addr_p0);
                        o_valid       <= 1'b1;
                        o_busy        <= 1'b0;
                        state         <= S_IDLE;
                    end else begin
                        lat_cnt <= lat_cnt - CNT_W'(1);
                    end
                end
                S_LOAD: begin
                    if (!i_load_en) begin
                        state        <= S_IDLE;
                        o_busy       <= 1'b0;
                        o_load_ready <= 1'b0;
                    end else if (i_load_valid) begin
                        // Out-of-range writes are dropped by the array but still counted.
                        o_load_count <= sat_inc(o_load_count);
                    end
                end
                default: begin
                    state        <= S_IDLE;
                    o_busy       <= 1'b0;
                    o_load_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mest_pro_imem.sv
// Bench for mest_pro_imem: a full-depth instance (256) and a short instance (200)
// share one stimulus stream and are checked against a transaction-level model.
module tb_mest_pro_imem;

    localparam int IW  = 4 + 24;
    localparam int LAT = 2;
    localparam int AW  = 8;
    localparam int DA  = 256;
    localparam int DB  = 200;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, req, load_en, load_valid;
    logic [AW-1:0] pc, load_addr;
    logic [IW-1:0] load_data;

    logic [IW-1:0] instr_a, instr_b;
    logic          vld_a, vld_b, busy_a, busy_b, err_a, err_b, rdy_a, rdy_b;
    logic [AW:0]   cnt_a, cnt_b;

    mest_pro_imem #(.ROM_DEPTH(DA), .READ_LATENCY(LAT)) dut_a (
        .clk(clk), .i_reset(rst), .i_req(req), .i_prog_counter(pc),
        .o_instruction(instr_a), .o_valid(vld_a), .o_busy(busy_a), .o_addr_err(err_a),
        .i_load_en(load_en), .i_load_valid(load_valid), .i_load_addr(load_addr),
        .i_load_data(load_data), .o_load_ready(rdy_a), .o_load_count(cnt_a)
    );

    mest_pro_imem #(.ROM_DEPTH(DB), .READ_LATENCY(LAT)) dut_b (
        .clk(clk), .i_reset(rst), .i_req(req), .i_prog_counter(pc),
        .o_instruction(instr_b), .o_valid(vld_b), .o_busy(busy_b), .o_addr_err(err_b),
        .i_load_en(load_en), .i_load_valid(load_valid), .i_load_addr(load_addr),
        .i_load_data(load_data), .o_load_ready(rdy_b), .o_load_count(cnt_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: memory contents per instance, load count, last returned word.
    logic [IW-1:0] ref_mem [2][256];
    int            ref_cnt;
    logic [IW-1:0] last_i [2];
    bit            last_e [2];
    int            wr_q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int depth(input int k);
        return (k == 0) ? DA : DB;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Record the word each instance must return for a read of address a.
    task automatic complete(input int a);
        for (int k = 0; k < 2; k++) begin
            last_e[k] = (a >= depth(k));
            last_i[k] = last_e[k] ? '0 : ref_mem[k][a];
        end
    endtask

    task automatic check_cycle(input string tag, input bit vld);
        check({tag, "_vld_a"}, vld_a, vld);
        check({tag, "_vld_b"}, vld_b, vld);
        check({tag, "_err_a"}, err_a, vld & last_e[0]);
        check({tag, "_err_b"}, err_b, vld & last_e[1]);
        check({tag, "_ins_a"}, instr_a, last_i[0]);
        check({tag, "_ins_b"}, instr_b, last_i[1]);
    endtask

    task automatic check_ctrl(input string tag, input bit busy, input bit rdy);
        check({tag, "_busy_a"}, busy_a, busy);
        check({tag, "_busy_b"}, busy_b, busy);
        check({tag, "_rdy_a"}, rdy_a, rdy);
        check({tag, "_rdy_b"}, rdy_b, rdy);
        check({tag, "_cnt_a"}, cnt_a, ref_cnt);
        check({tag, "_cnt_b"}, cnt_b, ref_cnt);
    endtask

    // Single read: one-cycle request, data exactly LAT edges after acceptance.
    task automatic do_read(input int a);
        req = 1'b1;
        pc  = a[AW-1:0];
        step();
        req = 1'b0;
        pc  = AW'($urandom);
        check("rd_busy_a", busy_a, 1);
        check("rd_busy_b", busy_b, 1);
        check_cycle("rd_acc", 0);
        for (int i = 1; i < LAT; i++) begin
            step();
            check_cycle("rd_wait", 0);
        end
        step();
        complete(a);
        check_cycle("rd_done", 1);
        step();
        check_cycle("rd_after", 0);
        check("rd_idle_a", busy_a, 0);
        check("rd_idle_b", busy_b, 0);
    endtask

    // Requests held high: acceptance every LAT+1 edges, other addresses ignored.
    task automatic do_b2b(input int a0, input int a1, input int a2);
        int lst [3];
        lst[0] = a0; lst[1] = a1; lst[2] = a2;
        for (int c = 0; c < 3 * (LAT + 1); c++) begin
            req = 1'b1;
            pc  = (c % (LAT + 1) == 0) ? lst[c / (LAT + 1)][AW-1:0] : AW'($urandom);
            step();
            if (c % (LAT + 1) == LAT) begin
                complete(lst[c / (LAT + 1)]);
                check_cycle("b2b", 1);
            end else begin
                check_cycle("b2b", 0);
            end
        end
        req = 1'b0;
        step();
        check_cycle("b2b_end", 0);
    endtask

    task automatic load_begin();
        load_en = 1'b1;
        step();
        ref_cnt = 0;
        check_ctrl("ld_entry", 1, 1);
    endtask

    task automatic load_write(input int a, input logic [IW-1:0] d);
        load_valid = 1'b1;
        load_addr  = a[AW-1:0];
        load_data  = d;
        step();
        load_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (a < depth(k)) ref_mem[k][a] = d;
        end
        wr_q.push_back(a);
        if (ref_cnt < 511) ref_cnt++;
        check("ld_cnt_a", cnt_a, ref_cnt);
        check("ld_cnt_b", cnt_b, ref_cnt);
    endtask

    task automatic load_end();
        load_en = 1'b0;
        step();
        check_ctrl("ld_exit", 0, 0);
        check_cycle("ld_exit", 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req = 1'b0; load_en = 1'b0; load_valid = 1'b0;
        pc = '0; load_addr = '0; load_data = '0;
        ref_cnt = 0;
        for (int k = 0; k < 2; k++) begin
            last_i[k] = '0;
            last_e[k] = 1'b0;
        end

        // Reset state.
        step();
        step();
        check_ctrl("rst", 0, 0);
        check_cycle("rst", 0);
        rst = 1'b0;
        step();
        check_ctrl("post_rst", 0, 0);

        // Directed program load.
        load_begin();
        load_write(0, 28'h1234567);
        load_write(1, 28'hABCDEF0);
        load_write(255, 28'h0000001);
        load_end();
        check("ld3_cnt", cnt_a, 3);

        // Single read, then data held through 20 idle cycles.
        do_read(1);
        for (int i = 0; i < 20; i++) begin
            step();
            check_cycle("hold", 0);
        end

        // Back-to-back reads with the request held.
        do_b2b(0, 1, 255);

        // Same-cycle request and load enable: load wins, fetch dropped.
        req = 1'b1; load_en = 1'b1; pc = 8'd5;
        step();
        req = 1'b0;
        ref_cnt = 0;
        check_ctrl("prio", 1, 1);
        check_cycle("prio", 0);
        load_write(5, 28'(($urandom)));
        step();
        check_cycle("prio_ld", 0);
        load_end();
        do_read(5);

        // Reset one cycle after acceptance aborts the read.
        req = 1'b1; pc = 8'd0;
        step();
        req = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        complete(0);
        last_i[0] = '0; last_i[1] = '0; last_e[0] = 1'b0; last_e[1] = 1'b0;
        for (int i = 0; i < LAT + 3; i++) begin
            step();
            check_cycle("rst_rd", 0);
        end
        do_read(1);

        // Reset during LOAD: the write strobed in the reset cycle is lost.
        load_begin();
        load_write(7, 28'h7777777);
        load_en = 1'b0; load_valid = 1'b1; load_addr = 8'd7; load_data = 28'h0BAD0BA;
        rst = 1'b1;
        step();
        rst = 1'b0; load_valid = 1'b0;
        ref_cnt = 0;
        last_i[0] = '0; last_i[1] = '0; last_e[0] = 1'b0; last_e[1] = 1'b0;
        check_ctrl("rst_ld", 0, 0);
        check_cycle("rst_ld", 0);
        do_read(7);

        // Write strobed in the LOAD exit cycle is not performed.
        load_begin();
        load_write(9, 28'h9999999);
        load_en = 1'b0; load_valid = 1'b1; load_addr = 8'd9; load_data = 28'h5555555;
        step();
        load_valid = 1'b0;
        check_ctrl("exit_wr", 0, 0);
        do_read(9);

        // Randomized load (including out-of-range addresses for the short instance).
        load_begin();
        load_write(210, 28'hD1D1D1D);
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                step();
                check("gap_cnt_a", cnt_a, ref_cnt);
            end
            load_write(int'($urandom_range(0, 255)), 28'($urandom));
        end
        load_end();
        do_read(210);

        // Randomized single and back-to-back reads of written addresses.
        for (int i = 0; i < 25; i++) begin
            do_read(wr_q[$urandom_range(0, wr_q.size() - 1)]);
        end
        for (int i = 0; i < 6; i++) begin
            do_b2b(wr_q[$urandom_range(0, wr_q.size() - 1)],
                   wr_q[$urandom_range(0, wr_q.size() - 1)],
                   wr_q[$urandom_range(0, wr_q.size() - 1)]);
        end

        // 300 writes: full 9-bit count, no saturation.
        load_begin();
        for (int i = 0; i < 300; i++) begin
            load_write(int'($urandom_range(0, 255)), 28'($urandom));
        end
        load_end();
        check("cnt300_a", cnt_a, 300);
        check("cnt300_b", cnt_b, 300);

        // 515 writes: count sticks at all-ones.
        load_begin();
        for (int i = 0; i < 515; i++) begin
            load_write(int'($urandom_range(0, 255)), 28'($urandom));
        end
        load_end();
        check("cnt_sat_a", cnt_a, 511);
        check("cnt_sat_b", cnt_b, 511);
        for (int i = 0; i < 10; i++) begin
            do_read(wr_q[$urandom_range(0, wr_q.size() - 1)]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
